// File: rtl/cache_pkg.sv
// Shared types and width helpers for the instruction cache.
//   state_e   : refill FSM states (IDLE, REQ, REFILL)
//   DEF_*     : address-field widths for the default geometry (22/6/2/2)
//   idx_w / off_w / tag_w : the same derivation for any parameterisation
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } state_e;

  localparam int BYTE_W = 2;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int tag_w(input int aw, input int sets, input int words);
    return aw - $clog2(sets) - $clog2(words) - BYTE_W;
  endfunction

  localparam int DEF_IDX_W = idx_w(64);
  localparam int DEF_OFF_W = off_w(4);
  localparam int DEF_TAG_W = tag_w(32, 64, 4);

endpackage

// File: rtl/inst_cache_array.sv
// Storage for the direct-mapped instruction cache.
//   rd_*_i / rd_*_o : asynchronous lookup of valid, tag and one data word
//   wr_*_i          : single word-write port (refill beats)
//   tag_we_i        : writes tag at wr_idx_i and sets valid to valid_set_i
//   clr_i           : flash-clears every valid bit (wins over a same-cycle set)
// Only the valid bits are reset; tag and data contents are left as-is.
module inst_cache_array
  import cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 6,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 22,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IDX_W-1:0]      rd_idx_i,
  input  logic [OFF_W-1:0]      rd_off_i,
  output logic                  rd_valid_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [OFF_W-1:0]      wr_off_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_W-1:0]      tag_wdata_i,
  input  logic                  valid_set_i,
  input  logic                  clr_i
);

  logic [SETS-1:0]       valid_q;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*LINE_WORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       valid_q <= '0;
    else if (clr_i)    valid_q <= '0;
    else if (tag_we_i) valid_q[wr_idx_i] <= valid_set_i;
  end

  always_ff @(posedge clk_i) begin
    if (tag_we_i) tag_q[wr_idx_i] <= tag_wdata_i;
    if (wr_en_i)  data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_off_i}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, blocking instruction cache with a single-line refill FSM.
//   clk, rst (async, active low)
//   addr / instr / stall : fetch side; combinational lookup, hit returns same cycle
//   flush                : invalidates all lines (fence.i)
//   mem_req / mem_addr / mem_gnt : refill request handshake (line-aligned address)
//   mem_rvalid / mem_rdata       : refill beats, LINE_WORDS per line, in order
module inst_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 64,
  parameter int LINE_WORDS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     stall,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int TAG_W  = tag_w(ADDRESS_WIDTH, SETS, LINE_WORDS);
  localparam int LINE_W = TAG_W + IDX_W;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             unused_byte;

  assign idx         = addr[BYTE_W+OFF_W +: IDX_W];
  assign off         = addr[BYTE_W +: OFF_W];
  assign tag         = addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign unused_byte = ^addr[BYTE_W-1:0];

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              fpend_q, fpend_d;
  logic [LINE_W-1:0] line_q, line_d;   // {tag,index} of the line being refilled

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;
  logic             wr_en, tag_we, valid_set;

  assign hit = rd_valid && (rd_tag == tag);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    line_d    = line_q;
    // A flush while a refill is outstanding must keep that line from going valid.
    fpend_d   = fpend_q | (flush && (state_q != IDLE));
    wr_en     = 1'b0;
    tag_we    = 1'b0;
    valid_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d = REQ;
          line_d  = {tag, idx};
        end
      end
      REQ: begin
        if (mem_gnt) state_d = REFILL;
      end
      REFILL: begin
        if (mem_rvalid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == OFF_W'(LINE_WORDS-1)) begin
            tag_we    = 1'b1;
            valid_set = !fpend_q;
            beat_d    = '0;
            fpend_d   = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      fpend_q <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fpend_q <= fpend_d;
      line_q  <= line_d;
    end
  end

  inst_cache_array #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W),
    .TAG_W      (TAG_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rd_idx_i    (idx),
    .rd_off_i    (off),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_data_o   (instr),
    .wr_en_i     (wr_en),
    .wr_idx_i    (line_q[IDX_W-1:0]),
    .wr_off_i    (beat_q),
    .wr_data_i   (mem_rdata),
    .tag_we_i    (tag_we),
    .tag_wdata_i (line_q[LINE_W-1 -: TAG_W]),
    .valid_set_i (valid_set),
    .clr_i       (flush)
  );

  assign stall    = (state_q != IDLE) || !hit;
  assign mem_req  = (state_q == REQ);
  assign mem_addr = {line_q, {(OFF_W+BYTE_W){1'b0}}};

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache (default geometry: tag[31:10] idx[9:4] off[3:2]).
// Expected instructions come from a memory model and are queued at issue time;
// a negedge monitor pops one entry for every non-stalled fetch cycle.
module tb_inst_cache;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] addr = '0, instr, mem_addr, mem_rdata;
  logic        stall, flush = 1'b0, mem_req, mem_gnt, mem_rvalid;

  // Memory side is driven either by the random responder or by directed code.
  logic        rsp_en = 1'b0;
  logic        r_gnt = 1'b0, r_rvalid = 1'b0;
  logic [31:0] r_rdata = '0;
  logic        d_gnt = 1'b0, d_rvalid = 1'b0;
  logic [31:0] d_rdata = '0;

  assign mem_gnt    = rsp_en ? r_gnt    : d_gnt;
  assign mem_rvalid = rsp_en ? r_rvalid : d_rvalid;
  assign mem_rdata  = rsp_en ? r_rdata  : d_rdata;

  int          n_tests = 0, n_fail = 0, cyc = 0, last_fill_cyc = -1;
  bit          fetch_en = 1'b0;
  logic [31:0] exp_q[$];
  bit          mv[64];          // model: line valid per index
  logic [21:0] mt[64];          // model: tag per index

  inst_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(64), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .instr(instr), .stall(stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_0193;
      default: return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && fetch_en && !stall) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: instr %h returned with nothing expected at %0t", instr, $time);
      end else begin
        chk("instr", instr, exp_q.pop_front());
      end
    end
  end

  // Random memory responder: grant delay, beat gaps, junk rvalid outside REFILL.
  initial begin
    logic [31:0] a;
    forever begin
      @(posedge clk); #1;
      r_rvalid = 1'b0;
      if (!rsp_en || !rst || !mem_req) begin
        r_rvalid = ($urandom_range(0, 3) == 0);
        r_rdata  = 32'hBAD0_0000 ^ $urandom;
        continue;
      end
      a = mem_addr;
      chk("rsp_mem_addr", a, {addr[31:4], 4'h0});
      repeat ($urandom_range(0, 3)) begin
        r_rvalid = 1'b1; r_rdata = 32'hBAD1_0000 ^ $urandom;
        @(posedge clk); #1;
        chk("rsp_req_hold", {mem_req, mem_addr}, {1'b1, a});
      end
      r_rvalid = 1'b0; r_gnt = 1'b1;
      @(posedge clk); #1;
      r_gnt = 1'b0;
      chk("rsp_refill_noreq", mem_req, 0);
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        r_rvalid = 1'b1; r_rdata = memw(a + 32'(4*i));
        @(posedge clk); #1;
        r_rvalid = 1'b0;
      end
      last_fill_cyc = cyc;
    end
  end

  // Random-phase fetch: call at posedge+1, returns at posedge+1.
  task automatic fetch(input logic [31:0] a, input bit fl);
    int          idx;
    logic [21:0] tg;
    bit          eh;
    int          n;
    idx = int'(a[9:4]); tg = a[31:10]; n = 0;
    eh  = mv[idx] && (mt[idx] == tg);
    exp_q.push_back(memw(a));
    addr = a; flush = fl; fetch_en = 1'b1;
    @(negedge clk);
    chk(eh ? "hit_nostall" : "miss_stall", stall, !eh);
    if (fl) model_clear();
    while (stall && n < 100) begin
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk); n++;
    end
    if (stall) begin
      n_tests++; n_fail++;
      $display("FAIL fetch_timeout: addr %h still stalled after %0d cycles", a, n);
    end else if (!eh) begin
      chk("miss_penalty", cyc, last_fill_cyc);
      mv[idx] = 1'b1; mt[idx] = tg;
    end
    @(posedge clk); #1;
    flush = 1'b0; fetch_en = 1'b0;
  endtask

  // Directed refill: call at a negedge with the cache already in REQ.
  task automatic man_fill(input logic [31:0] line, input int gw, input int fbeat);
    for (int i = 0; i < gw; i++) begin
      chk("gw_req", mem_req, 1);
      chk("gw_addr", mem_addr, line);
      chk("gw_stall", stall, 1);
      d_rvalid = 1'b1; d_rdata = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    chk("req", mem_req, 1);
    chk("req_addr", mem_addr, line);
    d_rvalid = 1'b0; d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    chk("refill_noreq", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      d_rvalid = 1'b1; d_rdata = memw(line + 32'(4*i)); flush = (i == fbeat);
      @(negedge clk);
      if (i < 3) chk("refill_stall", stall, 1);
    end
    d_rvalid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    model_clear();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 1);

    // Cold miss on 0x0, then sequential hit on 0x4.
    addr = 32'h0; fetch_en = 1'b1; exp_q.push_back(32'h0000_0013); rst = 1'b1;
    @(negedge clk);
    chk("cold_stall", stall, 1);
    chk("cold_noreq", mem_req, 0);
    @(negedge clk);
    man_fill(32'h0, 0, -1);
    chk("cold_done", stall, 0);
    @(posedge clk); #1;
    addr = 32'h4; exp_q.push_back(32'h0010_0093);
    @(negedge clk);
    chk("seq_hit", stall, 0);

    // Conflict on index 0, then refetch of 0x0 with a 5-cycle grant delay.
    @(posedge clk); #1;
    addr = 32'h400; exp_q.push_back(memw(32'h400));
    @(negedge clk);
    chk("conf_miss", stall, 1);
    @(negedge clk);
    man_fill(32'h400, 0, -1);
    chk("conf_done", stall, 0);
    @(posedge clk); #1;
    addr = 32'h0; exp_q.push_back(memw(32'h0));
    @(negedge clk);
    chk("conf_remiss", stall, 1);
    @(negedge clk);
    man_fill(32'h0, 5, -1);
    chk("gnt_wait_done", stall, 0);

    // Flush coincident with an IDLE hit, then flush during beat 2 of a refill.
    @(posedge clk); #1;
    flush = 1'b1; exp_q.push_back(memw(32'h0));
    @(negedge clk);
    chk("flush_hit", stall, 0);
    @(posedge clk); #1;
    flush = 1'b0; exp_q.push_back(memw(32'h0));
    @(negedge clk);
    chk("flush_miss", stall, 1);
    @(negedge clk);
    man_fill(32'h0, 1, 2);
    chk("fpend_stall", stall, 1);
    @(negedge clk);
    man_fill(32'h0, 0, -1);
    chk("refetch_done", stall, 0);

    // Reset after beat 1 of a refill of 0x40.
    @(posedge clk); #1;
    addr = 32'h40; exp_q.push_back(memw(32'h40));
    @(negedge clk);
    chk("rm_miss", stall, 1);
    @(negedge clk);
    chk("rm_req", mem_req, 1);
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = memw(32'h40);
    @(negedge clk);
    d_rdata = memw(32'h44);
    @(negedge clk);
    rst = 1'b0; d_rdata = 32'hDEAD_0002;
    #1;
    chk("rm_rst_req", mem_req, 0);
    chk("rm_rst_stall", stall, 1);
    @(negedge clk);
    rst = 1'b1; d_rdata = 32'hDEAD_0003;
    @(negedge clk);
    d_rvalid = 1'b0;
    chk("rm_remiss_stall", stall, 1);
    man_fill(32'h40, 0, -1);
    chk("rm_done", stall, 0);

    // Only line 0x40 survived the reset.
    model_clear();
    mv[4] = 1'b1; mt[4] = 22'h0;
    @(posedge clk); #1;
    fetch_en = 1'b0; rsp_en = 1'b1;

    for (int k = 0; k < 200; k++) begin
      a = {20'h0, 2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 2'($urandom), 2'($urandom)};
      fetch(a, $urandom_range(0, 15) == 0);
    end

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
